// File: rtl/data_memory_arbiter_if.sv
// Bundle of the CPU/debug requester ports and the data-memory port of the arbiter.
// Requesters see the master view and the arbiter sees the slave view.
interface data_memory_arbiter_if;
  logic       cpu_req;
  logic       cpu_we;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_gnt;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;

  logic       dbg_req;
  logic       dbg_we;
  logic [7:0] dbg_addr;
  logic [7:0] dbg_wdata;
  logic       dbg_gnt;
  logic       dbg_ack;
  logic [7:0] dbg_rdata;

  logic [7:0] mem_address;
  logic [7:0] mem_data_in;
  logic       mem_write_enable;
  logic [7:0] mem_data_out;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_ack, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_ack, dbg_rdata,
    input  mem_address, mem_data_in, mem_write_enable,
    output mem_data_out
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_ack, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_ack, dbg_rdata,
    output mem_address, mem_data_in, mem_write_enable,
    input  mem_data_out
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Round-robin CPU/debug arbiter for one data memory: gnt one cycle after the request, ack one after that.
// Requesters stall by holding req until ack; dropping req during the grant abandons the access.
module data_memory_arbiter (
  input  logic                  clk,
  input  logic                  rst_n,
  data_memory_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_CPU,
    SERVE_DBG,
    ACK
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       last;
  logic       cpu_done;
  logic       dbg_done;
  logic       cpu_ack_q;
  logic       dbg_ack_q;
  logic [7:0] cpu_rdata_q;
  logic [7:0] dbg_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last        <= 1'b1;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      cpu_rdata_q <= 8'h00;
      dbg_rdata_q <= 8'h00;
    end else begin
      state     <= state_nxt;
      cpu_ack_q <= cpu_done;
      dbg_ack_q <= dbg_done;
      if (cpu_done) begin
        last <= 1'b0;
        if (!bus.cpu_we) cpu_rdata_q <= bus.mem_data_out;
      end
      if (dbg_done) begin
        last <= 1'b1;
        if (!bus.dbg_we) dbg_rdata_q <= bus.mem_data_out;
      end
    end
  end

  always_comb begin
    state_nxt            = state;
    cpu_done             = 1'b0;
    dbg_done             = 1'b0;
    bus.cpu_gnt          = 1'b0;
    bus.dbg_gnt          = 1'b0;
    bus.mem_address      = 8'h00;
    bus.mem_data_in      = 8'h00;
    bus.mem_write_enable = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the port that was not served last wins.
        if (bus.cpu_req && bus.dbg_req) state_nxt = last ? SERVE_CPU : SERVE_DBG;
        else if (bus.cpu_req)           state_nxt = SERVE_CPU;
        else if (bus.dbg_req)           state_nxt = SERVE_DBG;
      end
      SERVE_CPU: begin
        bus.cpu_gnt          = 1'b1;
        bus.mem_address      = bus.cpu_addr;
        bus.mem_data_in      = bus.cpu_wdata;
        bus.mem_write_enable = bus.cpu_we & bus.cpu_req;
        cpu_done             = bus.cpu_req;
        state_nxt            = bus.cpu_req ? ACK : IDLE;
      end
      SERVE_DBG: begin
        bus.dbg_gnt          = 1'b1;
        bus.mem_address      = bus.dbg_addr;
        bus.mem_data_in      = bus.dbg_wdata;
        bus.mem_write_enable = bus.dbg_we & bus.dbg_req;
        dbg_done             = bus.dbg_req;
        state_nxt            = bus.dbg_req ? ACK : IDLE;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dbg_ack   = dbg_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed scenarios plus a random soak, checked against a transaction-level model.
module tb_data_memory_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  data_memory_arbiter_if bus ();
  data_memory_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endfunction

  // Data memory: combinational read, synchronous write, preloadable by the bench.
  logic       mem_load  = 1'b0;
  logic [7:0] load_addr = 8'h00;
  logic [7:0] load_data = 8'h00;
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_load)                 mem[load_addr] <= load_data;
    else if (bus.mem_write_enable) mem[bus.mem_address] <= bus.mem_data_in;
  end
  assign bus.mem_data_out = mem[bus.mem_address];

  // Port views indexed 0 = CPU, 1 = DBG.
  function automatic logic req_of(int p);          return p == 0 ? bus.cpu_req   : bus.dbg_req;   endfunction
  function automatic logic we_of(int p);           return p == 0 ? bus.cpu_we    : bus.dbg_we;    endfunction
  function automatic logic [7:0] addr_of(int p);   return p == 0 ? bus.cpu_addr  : bus.dbg_addr;  endfunction
  function automatic logic [7:0] wdata_of(int p);  return p == 0 ? bus.cpu_wdata : bus.dbg_wdata; endfunction

  // Model: an access goes through phase 0 (waiting), 1 (granted to m_who), 2 (acknowledging).
  int         m_phase = 0;
  int         m_who   = 0;
  int         m_last  = 1;
  logic [7:0] m_rdata [2] = '{8'h00, 8'h00};
  logic [7:0] ref_mem [256];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase    = 0;
      m_last     = 1;
      m_rdata[0] = 8'h00;
      m_rdata[1] = 8'h00;
    end else begin
      case (m_phase)
        0: if (req_of(0) || req_of(1)) begin
             m_who   = (req_of(0) && req_of(1)) ? 1 - m_last : (req_of(1) ? 1 : 0);
             m_phase = 1;
           end
        1: if (req_of(m_who)) begin
             m_last = m_who;
             if (we_of(m_who)) ref_mem[addr_of(m_who)] = wdata_of(m_who);
             else              m_rdata[m_who] = ref_mem[addr_of(m_who)];
             m_phase = 2;
           end else begin
             m_phase = 0;
           end
        default: m_phase = 0;
      endcase
    end
    if (mem_load) ref_mem[load_addr] = load_data;
  end

  always @(negedge clk) begin
    logic serving;
    logic acking;
    serving = (m_phase == 1);
    acking  = (m_phase == 2);
    check("cpu_gnt",   bus.cpu_gnt, serving && m_who == 0);
    check("dbg_gnt",   bus.dbg_gnt, serving && m_who == 1);
    check("cpu_ack",   bus.cpu_ack, acking && m_who == 0);
    check("dbg_ack",   bus.dbg_ack, acking && m_who == 1);
    check("mem_address", bus.mem_address, serving ? addr_of(m_who) : 8'h00);
    check("mem_data_in", bus.mem_data_in, serving ? wdata_of(m_who) : 8'h00);
    check("mem_write_enable", bus.mem_write_enable, serving && req_of(m_who) && we_of(m_who));
    check("cpu_rdata", bus.cpu_rdata, m_rdata[0]);
    check("dbg_rdata", bus.dbg_rdata, m_rdata[1]);
    check("gnt_exclusive", bus.cpu_gnt & bus.dbg_gnt, 8'h00);
    check("ack_exclusive", bus.cpu_ack & bus.dbg_ack, 8'h00);
    check("we_only_when_granted", bus.mem_write_enable & ~(bus.cpu_gnt | bus.dbg_gnt), 8'h00);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(int p, logic req, logic we, logic [7:0] addr, logic [7:0] wdata);
    if (p == 0) begin
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end else begin
      bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata;
    end
  endtask

  task automatic clear_ports();
    set_port(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_port(1, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // One complete access on port p; returns how many cycles had the write strobe up.
  task automatic access(int p, logic we, logic [7:0] addr, logic [7:0] wdata, output int wr_cycles);
    bit got_ack;
    got_ack   = 1'b0;
    wr_cycles = 0;
    set_port(p, 1'b1, we, addr, wdata);
    for (int i = 0; i < 8; i++) begin
      if (bus.mem_write_enable) wr_cycles++;
      if ((p == 0 ? bus.cpu_ack : bus.dbg_ack) === 1'b1) begin
        got_ack = 1'b1;
        break;
      end
      tick();
    end
    check("ack_within_bound", got_ack, 8'h01);
    set_port(p, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
  endtask

  initial begin
    int wr;
    clear_ports();
    #1 rst_n = 1'b0;
    for (int a = 0; a < 256; a++) begin
      mem_load  = 1'b1;
      load_addr = 8'(a);
      load_data = 8'(a) ^ 8'h4A;
      tick();
    end
    mem_load = 1'b0;
    check("reset_cpu_rdata", bus.cpu_rdata, 8'h00);
    check("reset_dbg_ack",   bus.dbg_ack,   8'h00);
    rst_n = 1'b1;

    // Both requesting from the first edge: CPU wins the first tie, then strict alternation.
    set_port(0, 1'b1, 1'b0, 8'h10, 8'h00);
    set_port(1, 1'b1, 1'b0, 8'h20, 8'h00);
    for (int c = 0; c < 12; c++) begin
      check("seq_cpu_gnt", bus.cpu_gnt, (c == 1 || c == 7));
      check("seq_dbg_gnt", bus.dbg_gnt, (c == 4 || c == 10));
      check("seq_cpu_ack", bus.cpu_ack, (c == 2 || c == 8));
      check("seq_dbg_ack", bus.dbg_ack, (c == 5 || c == 11));
      if (c == 1) check("cpu_read_addr", bus.mem_address, 8'h10);
      if (c == 2) check("cpu_read_data", bus.cpu_rdata, 8'h5A);
      if (c == 5) check("dbg_read_data", bus.dbg_rdata, 8'h6A);
      tick();
    end
    clear_ports();
    tick();

    // DBG write then CPU read-back.
    access(1, 1'b1, 8'h20, 8'hC3, wr);
    check("dbg_write_one_cycle", 8'(wr), 8'h01);
    access(0, 1'b0, 8'h20, 8'h00, wr);
    check("cpu_readback", bus.cpu_rdata, 8'hC3);

    // Withdrawal: CPU wins the tie (DBG served last), drops req in SERVE; DBG goes next.
    access(1, 1'b0, 8'h50, 8'h00, wr);
    set_port(0, 1'b1, 1'b1, 8'h40, 8'h11);
    set_port(1, 1'b1, 1'b0, 8'h50, 8'h00);
    tick();
    check("wd_cpu_gnt", bus.cpu_gnt, 8'h01);
    check("wd_we_before", bus.mem_write_enable, 8'h01);
    bus.cpu_req = 1'b0;
    #1;
    check("wd_we_after_drop", bus.mem_write_enable, 8'h00);
    tick();
    check("wd_no_cpu_ack", bus.cpu_ack, 8'h00);
    check("wd_idle_no_gnt", bus.cpu_gnt | bus.dbg_gnt, 8'h00);
    tick();
    check("wd_dbg_gnt", bus.dbg_gnt, 8'h01);
    tick();
    check("wd_dbg_ack", bus.dbg_ack, 8'h01);
    clear_ports();
    tick();
    check("wd_mem_untouched", mem[8'h40], 8'h0A);

    // Reset in the middle of a DBG write.
    set_port(1, 1'b1, 1'b1, 8'h30, 8'h77);
    tick();
    check("rst_dbg_gnt_before", bus.dbg_gnt, 8'h01);
    check("rst_we_before", bus.mem_write_enable, 8'h01);
    rst_n = 1'b0;
    #1;
    check("rst_we_dropped", bus.mem_write_enable, 8'h00);
    check("rst_gnt_dropped", bus.dbg_gnt, 8'h00);
    check("rst_addr_zero", bus.mem_address, 8'h00);
    check("rst_cpu_rdata", bus.cpu_rdata, 8'h00);
    check("rst_acks", bus.cpu_ack | bus.dbg_ack, 8'h00);
    tick();
    check("rst_mem_untouched", mem[8'h30], 8'h7A);
    clear_ports();
    rst_n = 1'b1;
    tick();

    // Reset while acknowledging cancels the ack.
    set_port(0, 1'b1, 1'b0, 8'h10, 8'h00);
    tick();
    tick();
    check("ackrst_ack_before", bus.cpu_ack, 8'h01);
    check("ackrst_rdata", bus.cpu_rdata, 8'h5A);
    rst_n = 1'b0;
    #1;
    check("ackrst_ack_cancelled", bus.cpu_ack, 8'h00);
    check("ackrst_rdata_cleared", bus.cpu_rdata, 8'h00);
    clear_ports();
    tick();
    rst_n = 1'b1;
    tick();

    // Random soak; the compare process checks every cycle.
    for (int i = 0; i < 10000; i++) begin
      set_port(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      set_port(1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      tick();
    end
    clear_ports();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock) and rst_n input 1 (asynchronous active-low reset).
REQ-002 The block SHALL provide the CPU requester port:
- cpu_req input 1: access request.
- cpu_we input 1: 1 = write, 0 = read.
- cpu_addr input 8: address.
- cpu_wdata input 8: write data.
- cpu_gnt output 1: CPU port owns the memory.
- cpu_ack output 1: access complete.
- cpu_rdata output 8: read data.
REQ-003 The block SHALL provide the debug requester port: dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_ack and dbg_rdata, with the same directions, widths and meanings as the CPU port.
REQ-004 The block SHALL provide the memory port:
- mem_address output 8.
- mem_data_in output 8.
- mem_write_enable output 1.
- mem_data_out input 8: combinational read data from the data memory, whose write is synchronous.

Function
REQ-005 The block SHALL implement states IDLE, SERVE_CPU, SERVE_DBG and ACK, plus a 1-bit last-served pointer (last: 0 = CPU, 1 = DBG).
REQ-006 The IDLE transitions SHALL be:
- cpu_req only -> SERVE_CPU.
- dbg_req only -> SERVE_DBG.
- both requests -> serve the port not equal to last.
- neither request -> stay in IDLE.
REQ-007 In SERVE_x the block SHALL assert x_gnt and drive mem_address = x_addr and mem_data_in = x_wdata.
REQ-008 In SERVE_x the block SHALL drive mem_write_enable = x_we AND x_req.
REQ-009 mem_write_enable SHALL be 0 in every state other than SERVE_x.
REQ-010 Outside SERVE states the block SHALL drive mem_address = 0, mem_data_in = 0, and both gnt outputs low.
REQ-011 SERVE_x with x_req = 1 SHALL, at the clock edge:
- transition to ACK;
- set last = x;
- register x_rdata <= mem_data_out for reads;
- leave x_rdata unchanged for writes.
REQ-012 SERVE_x with x_req = 0 (request withdrawn) SHALL return to IDLE with no write, no ack, and last unchanged.
REQ-013 In ACK the block SHALL assert x_ack, registered, for exactly one cycle for the port just served, then unconditionally return to IDLE.
REQ-014 Latency SHALL be fixed: a request sampled in IDLE at edge N gives gnt in cycle N+1 and ack in cycle N+2.
REQ-015 The minimum access period SHALL be 3 cycles (IDLE, SERVE, ACK); the arbiter never serves back-to-back without passing through IDLE.
REQ-016 The requester SHALL hold req, we, addr and wdata stable from assertion until ack; the arbiter does not latch request fields.
REQ-017 A requester holding req high after its ack SHALL be treated as a new request in IDLE.
REQ-018 With both ports continuously requesting, grants SHALL strictly alternate CPU, DBG, CPU, ..., so neither port waits more than one foreign access (at most 3 extra cycles).
REQ-019 Exactly one or zero of cpu_gnt and dbg_gnt SHALL be high in any cycle.
REQ-020 Exactly one or zero of cpu_ack and dbg_ack SHALL be high in any cycle.
REQ-021 x_rdata SHALL hold its value until the next read completion for port x.

Reset
REQ-022 While rst_n = 0, asynchronously and regardless of clk, the block SHALL set:
- state = IDLE;
- last = 1 (DBG), so the CPU wins the first tie;
- cpu_ack = dbg_ack = 0;
- cpu_rdata = dbg_rdata = 0x00.
REQ-023 Reset asserted during SERVE_x SHALL drop mem_write_enable and x_gnt combinationally in the same cycle, and no write SHALL occur at the following edge.
REQ-024 Reset asserted during ACK SHALL cancel the pending ack.
REQ-025 After rst_n deassertion, the first arbitration SHALL occur at the first rising clk edge.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- CPU read: memory[0x10] = 0x5A; cpu_req = 1, cpu_we = 0, cpu_addr = 0x10 -> cpu_gnt high in cycle N+1 with mem_address = 0x10; cpu_ack high in cycle N+2 with cpu_rdata = 0x5A.
- DBG write: dbg_req = 1, dbg_we = 1, dbg_addr = 0x20, dbg_wdata = 0xC3 -> mem_write_enable = 1 for exactly one cycle; a later CPU read of 0x20 returns 0xC3.
- Simultaneous first request after reset: both req high -> CPU served first. With both held high, the grant sequence over 12 cycles is CPU, DBG, CPU, DBG, and acks land on cycles 2, 5, 8, 11.
- Withdrawal: cpu_req = 1, cpu_we = 1; drop cpu_req during SERVE_CPU -> mem_write_enable = 0, no cpu_ack, state IDLE, and a pending dbg_req is served next (last unchanged).
- Reset mid-access: rst_n -> 0 during SERVE_DBG write of 0x77 to 0x30 -> mem_write_enable and dbg_gnt low immediately, memory[0x30] unchanged, all outputs at reset values.
- Grant exclusivity assertion checked over 10,000 random cycles: cpu_gnt AND dbg_gnt never high together, cpu_ack AND dbg_ack never high together, and mem_write_enable is high only in SERVE states.
